// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared types for the decision-tree classifier blocks.
package dtc_pkg;

    typedef logic [1:0] dtc_class_t;

    localparam int NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DECIDE = 2'd1,
        HOLD   = 2'd2
    } dtc_vote_state_e;

endpackage

// File: rtl/dtc_vote_window_if.sv
// rtl/dtc_vote_window_if.sv - prediction input and decision output handshakes of dtc_vote_window.
// out_counts exists only when DTC_VOTE_COUNTS_EN is defined.
interface dtc_vote_window_if
    import dtc_pkg::*;
#(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    dtc_class_t       in_class;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    dtc_class_t       out_class;
    logic [CNT_W-1:0] out_conf;
    logic             out_tie;
`ifdef DTC_VOTE_COUNTS_EN
    logic [NUM_CLASSES*CNT_W-1:0] out_counts;
`endif

    modport slave (
        input  in_valid, in_class, flush, out_ready,
        output in_ready, out_valid, out_class, out_conf, out_tie
`ifdef DTC_VOTE_COUNTS_EN
        , output out_counts
`endif
    );

    modport master (
        output in_valid, in_class, flush, out_ready,
        input  in_ready, out_valid, out_class, out_conf, out_tie
`ifdef DTC_VOTE_COUNTS_EN
        , input out_counts
`endif
    );

endinterface

// File: rtl/dtc_vote_argmax.sv
// rtl/dtc_vote_argmax.sv - combinational 4-way argmax, lowest index wins equal counts.
module dtc_vote_argmax
    import dtc_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [NUM_CLASSES*CNT_W-1:0] counts,
    output dtc_class_t                   winner,
    output logic [CNT_W-1:0]             max_cnt,
    output logic                         tie
);

    always_comb begin
        winner  = '0;
        max_cnt = counts[CNT_W-1:0];
        tie     = 1'b0;
        // Strict greater-than keeps the earlier index on equal counts.
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (counts[i*CNT_W +: CNT_W] > max_cnt) begin
                max_cnt = counts[i*CNT_W +: CNT_W];
                winner  = dtc_class_t'(i);
            end
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (dtc_class_t'(i) != winner && counts[i*CNT_W +: CNT_W] == max_cnt) begin
                tie = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_vote_window.sv
// rtl/dtc_vote_window.sv - per-window majority vote over a stream of class predictions.
// Define DTC_VOTE_COUNTS_EN to expose the per-class count snapshot on out_counts.
module dtc_vote_window
    import dtc_pkg::*;
#(
    parameter int WINDOW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dtc_vote_window_if.slave   bus
);

    localparam int               CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN_N = CNT_W'(WINDOW);

    dtc_vote_state_e              state_q, state_d;
    logic [NUM_CLASSES*CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]             n_seen_q, n_post;
    logic                         in_ready_c, accept, out_fire;

    logic                         out_valid_q, out_tie_q;
    dtc_class_t                   out_class_q;
    logic [CNT_W-1:0]             out_conf_q;

    dtc_class_t                   am_winner;
    logic [CNT_W-1:0]             am_max;
    logic                         am_tie;

    assign accept   = in_ready_c && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;
    assign n_post   = n_seen_q + CNT_W'(accept);

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_c = 1'b1;
                // A flush that arrives with a sample counts that sample first.
                if ((bus.in_valid && n_post == WIN_N) || (bus.flush && n_post != '0))
                    state_d = DECIDE;
            end
            DECIDE:  state_d = HOLD;
            HOLD:    if (out_fire) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            n_seen_q <= '0;
        end else if (out_fire) begin
            cnt_q    <= '0;
            n_seen_q <= '0;
        end else if (accept) begin
            n_seen_q <= n_post;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (bus.in_class == dtc_class_t'(i))
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    dtc_vote_argmax #(.CNT_W(CNT_W)) u_argmax (
        .counts  (cnt_q),
        .winner  (am_winner),
        .max_cnt (am_max),
        .tie     (am_tie)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_conf_q  <= '0;
            out_tie_q   <= 1'b0;
        end else if (state_q == DECIDE) begin
            out_valid_q <= 1'b1;
            out_class_q <= am_winner;
            out_conf_q  <= am_max;
            out_tie_q   <= am_tie;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef DTC_VOTE_COUNTS_EN
    logic [NUM_CLASSES*CNT_W-1:0] out_counts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  out_counts_q <= '0;
        else if (state_q == DECIDE)  out_counts_q <= cnt_q;
    end

    assign bus.out_counts = out_counts_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_conf  = out_conf_q;
    assign bus.out_tie   = out_tie_q;

endmodule

// File: tb/tb_dtc_vote_window.sv
// tb/tb_dtc_vote_window.sv - self-checking bench for dtc_vote_window with WINDOW=4.
module tb_dtc_vote_window;
    import dtc_pkg::*;

    localparam int WINDOW = 4;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dtc_vote_window_if #(.CNT_W(CNT_W)) bus ();

    dtc_vote_window #(.WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        dtc_class_t             cls;
        int                     conf;
        bit                     tie;
        logic [4*CNT_W-1:0]     counts;
    } exp_t;

    typedef struct {
        int                     n;
        logic [3:0][1:0]        smp;
        int                     fmode;   // 0 none, 1 flush alone after samples, 2 flush with last sample
        exp_t                   e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input int c, input int f, input bit t,
                                    input int k0, input int k1, input int k2, input int k3);
        exp_t e;
        e.cls    = dtc_class_t'(c);
        e.conf   = f;
        e.tie    = t;
        e.counts = {CNT_W'(k3), CNT_W'(k2), CNT_W'(k1), CNT_W'(k0)};
        return e;
    endfunction

    function automatic vec_t mk(input int n, input int a, input int b, input int c, input int d,
                                input int fm, input exp_t e);
        vec_t v;
        v.n      = n;
        v.smp[0] = dtc_class_t'(a);
        v.smp[1] = dtc_class_t'(b);
        v.smp[2] = dtc_class_t'(c);
        v.smp[3] = dtc_class_t'(d);
        v.fmode  = fm;
        v.e      = e;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input dtc_class_t c, input bit fl);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_class = c;
        bus.flush    = fl;
        while (!bus.in_ready && w < 50) begin
            step();
            w++;
        end
        chk("in_ready_wait", int'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"},  int'(bus.in_ready),  1);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_class"}, int'(bus.out_class), 0);
        chk({tag, "_out_conf"},  int'(bus.out_conf),  0);
        chk({tag, "_out_tie"},   int'(bus.out_tie),   0);
`ifdef DTC_VOTE_COUNTS_EN
        chk({tag, "_out_counts"}, int'(bus.out_counts), 0);
`endif
    endtask

    // Scoreboard pops on every completed output handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output class=%0d conf=%0d expected=none", bus.out_class, bus.out_conf);
            end else begin
                e = sb.pop_front();
                chk("out_class", int'(bus.out_class), int'(e.cls));
                chk("out_conf",  int'(bus.out_conf),  e.conf);
                chk("out_tie",   int'(bus.out_tie),   int'(e.tie));
`ifdef DTC_VOTE_COUNTS_EN
                chk("out_counts", int'(bus.out_counts), int'(e.counts));
`endif
            end
        end
    end

    initial begin
        exp_t hold_e;
        int   w;

        bus.in_valid  = 1'b0;
        bus.in_class  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        step();
        step();
        reset_checks("reset");
        rst_n = 1'b1;
        step();

        vecs[0] = mk(4, 2, 2, 1, 2, 0, mk_exp(2, 3, 0, 0, 1, 3, 0));
        vecs[1] = mk(4, 1, 3, 1, 3, 0, mk_exp(1, 2, 1, 0, 2, 0, 2));
        vecs[2] = mk(3, 0, 3, 3, 0, 1, mk_exp(3, 2, 0, 1, 0, 0, 2));
        vecs[3] = mk(4, 0, 1, 2, 3, 0, mk_exp(0, 1, 1, 1, 1, 1, 1));
        vecs[4] = mk(4, 3, 3, 3, 3, 0, mk_exp(3, 4, 0, 0, 0, 0, 4));
        vecs[5] = mk(1, 2, 0, 0, 0, 2, mk_exp(2, 1, 0, 0, 0, 1, 0));

        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].e);
            for (int i = 0; i < vecs[v].n; i++)
                put(vecs[v].smp[i], (vecs[v].fmode == 2) && (i == vecs[v].n - 1));
            if (vecs[v].fmode == 1) begin
                bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
            end
            chk("decide_out_valid", int'(bus.out_valid), 0);
            chk("decide_in_ready",  int'(bus.in_ready),  0);
            step();
            chk("hold_out_valid", int'(bus.out_valid), 1);
            step();
            chk("after_hs_in_ready",  int'(bus.in_ready),  1);
            chk("after_hs_out_valid", int'(bus.out_valid), 0);
        end

        // Flush on an empty window must not produce a decision.
        bus.flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("empty_flush_in_ready",  int'(bus.in_ready),  1);
            chk("empty_flush_out_valid", int'(bus.out_valid), 0);
        end
        bus.flush = 1'b0;

        // Back-pressure in HOLD: outputs frozen, inputs and flush ignored.
        bus.out_ready = 1'b0;
        hold_e = mk_exp(2, 3, 0, 0, 1, 3, 0);
        sb.push_back(hold_e);
        put(2'd2, 1'b0); put(2'd2, 1'b0); put(2'd1, 1'b0); put(2'd2, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_class = 2'd3;
            bus.flush    = 1'b1;
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_class", int'(bus.out_class), int'(hold_e.cls));
            chk("stall_out_conf",  int'(bus.out_conf),  hold_e.conf);
            chk("stall_in_ready",  int'(bus.in_ready),  0);
`ifdef DTC_VOTE_COUNTS_EN
            chk("stall_out_counts", int'(bus.out_counts), int'(hold_e.counts));
`endif
            step();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("release_in_ready", int'(bus.in_ready), 1);
        sb.push_back(mk_exp(0, 2, 0, 2, 1, 0, 1));
        put(2'd0, 1'b0); put(2'd1, 1'b0); put(2'd0, 1'b0); put(2'd3, 1'b0);
        step();
        step();

        // Reset mid-window discards the partial counts.
        put(2'd3, 1'b0);
        put(2'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        reset_checks("midwin_reset");
        step();
        rst_n = 1'b1;
        step();
        sb.push_back(mk_exp(0, 2, 0, 2, 1, 1, 0));
        put(2'd0, 1'b0); put(2'd0, 1'b0); put(2'd1, 1'b0); put(2'd2, 1'b0);
        step();
        step();

        // Reset during HOLD drops the pending decision.
        bus.out_ready = 1'b0;
        put(2'd1, 1'b0); put(2'd1, 1'b0); put(2'd1, 1'b0); put(2'd1, 1'b0);
        step();
        chk("hold_before_reset", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        reset_checks("hold_reset");
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("post_hold_reset_out_valid", int'(bus.out_valid), 0);

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            step();
            w++;
        end
        chk("scoreboard_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
